// File: rtl/fir_interpolator.sv
// Polyphase FIR interpolator: each I/Q input pair yields L filtered I/Q output pairs.
// Coefficients are supplied through the COEFFS parameter; entry j sits at bits [j*CSZ +: CSZ].
module fir_interpolator #(
  parameter int ISZ  = 16,
  parameter int OSZ  = 16,
  parameter int CSZ  = 16,
  parameter int L    = 8,
  parameter int TAPS = 32,
  parameter int AGRW = 3,
  parameter logic [TAPS*CSZ-1:0] COEFFS = '0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  input  logic [ISZ-1:0] in,
  output logic           in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OSZ-1:0] out,
  output logic           out_q
);

  localparam int NT  = TAPS / L;
  localparam int PSZ = ISZ + CSZ;
  localparam int ASZ = ISZ + CSZ + AGRW;
  localparam int SW  = ASZ - CSZ + 1;
  localparam int PW  = (L > 1) ? $clog2(L) : 1;
  localparam int KW  = (NT > 1) ? $clog2(NT) : 1;
  localparam int CW  = $clog2(NT + 3);
  localparam int TW  = (TAPS > 1) ? $clog2(TAPS) : 1;

  // CALC schedule: read at cnt 0..NT-1, multiply one cycle later, accumulate one after that.
  localparam logic [CW-1:0] CntReadEnd  = CW'(NT);
  localparam logic [CW-1:0] CntAccFirst = CW'(2);
  localparam logic [CW-1:0] CntAccLast  = CW'(NT + 1);
  localparam logic [CW-1:0] CntDone     = CW'(NT + 2);
  localparam logic [PW-1:0] PLast       = PW'(L - 1);

  localparam logic signed [ASZ-1:0] Round = ASZ'(64'sd1 <<< (CSZ - 2));
  localparam logic signed [SW-1:0]  SatHi = SW'((64'sd1 <<< (OSZ - 1)) - 64'sd1);
  localparam logic signed [SW-1:0]  SatLo = SW'(-(64'sd1 <<< (OSZ - 1)));

  typedef enum logic [1:0] {StIdle, StCalc, StOut} state_e;

  state_e                 state_q, state_d;
  logic                   started_q;
  logic                   iq_q;  // 1 when the next accepted input word is a Q word
  logic signed [ISZ-1:0]  stage_i_q;
  logic signed [ISZ-1:0]  hist_i_q [NT];
  logic signed [ISZ-1:0]  hist_q_q [NT];
  logic [PW-1:0]          p_q;
  logic                   c_q;
  logic [CW-1:0]          cnt_q;
  logic signed [ISZ-1:0]  rd_x_q;
  logic signed [CSZ-1:0]  rd_c_q;
  logic signed [PSZ-1:0]  prod_q;
  logic signed [ASZ-1:0]  acc_q;
  logic [OSZ-1:0]         word_q;

  logic                   in_fire, q_fire, out_fire;
  logic                   in_calc, rd_en, acc_en, calc_done, calc_enter;
  logic [KW-1:0]          rd_k;
  logic [TW-1:0]          coef_idx;
  logic signed [CSZ-1:0]  rom [TAPS];
  logic signed [SW-1:0]   acc_shr;
  logic [OSZ-1:0]         sat_word;
  logic                   unused_acc_lsb;

  for (genvar j = 0; j < TAPS; j++) begin : g_rom
    assign rom[j] = COEFFS[j*CSZ +: CSZ];
  end

  assign in_ready  = started_q && (state_q == StIdle);
  assign out_valid = (state_q == StOut);
  assign out       = word_q;
  assign out_q     = c_q;

  assign in_fire  = in_valid & in_ready;
  assign q_fire   = in_fire & iq_q;
  assign out_fire = out_valid & out_ready;

  assign in_calc   = (state_q == StCalc);
  assign rd_en     = in_calc && (cnt_q < CntReadEnd);
  assign acc_en    = in_calc && (cnt_q >= CntAccFirst) && (cnt_q <= CntAccLast);
  assign calc_done = in_calc && (cnt_q == CntDone);

  assign rd_k     = cnt_q[KW-1:0];
  assign coef_idx = TW'(p_q) + TW'(L) * TW'(rd_k);

  assign acc_shr        = acc_q[ASZ-1:CSZ-1];
  assign unused_acc_lsb = ^acc_q[CSZ-2:0];

  always_comb begin
    sat_word = acc_shr[OSZ-1:0];
    if (acc_shr > SatHi) begin
      sat_word = {1'b0, {(OSZ-1){1'b1}}};
    end else if (acc_shr < SatLo) begin
      sat_word = {1'b1, {(OSZ-1){1'b0}}};
    end
  end

  always_comb begin
    state_d    = state_q;
    calc_enter = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (q_fire) begin
          state_d    = StCalc;
          calc_enter = 1'b1;
        end
      end
      StCalc: begin
        if (calc_done) state_d = StOut;
      end
      StOut: begin
        if (out_fire) begin
          if (!c_q || (p_q != PLast)) begin
            state_d    = StCalc;
            calc_enter = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started_q <= 1'b0;
      iq_q      <= 1'b0;
      stage_i_q <= '0;
      for (int k = 0; k < NT; k++) begin
        hist_i_q[k] <= '0;
        hist_q_q[k] <= '0;
      end
      p_q    <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      rd_x_q <= '0;
      rd_c_q <= '0;
      prod_q <= '0;
      acc_q  <= '0;
      word_q <= '0;
    end else begin
      started_q <= 1'b1;

      if (in_fire) begin
        iq_q <= ~iq_q;
        if (!iq_q) begin
          stage_i_q <= $signed(in);
        end else begin
          for (int k = NT - 1; k > 0; k--) begin
            hist_i_q[k] <= hist_i_q[k-1];
            hist_q_q[k] <= hist_q_q[k-1];
          end
          hist_i_q[0] <= stage_i_q;
          hist_q_q[0] <= $signed(in);
        end
      end

      if (q_fire) begin
        p_q <= '0;
        c_q <= 1'b0;
      end else if (out_fire) begin
        if (!c_q) begin
          c_q <= 1'b1;
        end else if (p_q != PLast) begin
          p_q <= p_q + 1'b1;
          c_q <= 1'b0;
        end
      end

      if (calc_enter) begin
        cnt_q <= '0;
        acc_q <= Round;
      end else begin
        if (in_calc) cnt_q <= cnt_q + 1'b1;
        if (acc_en)  acc_q <= acc_q + $signed({{AGRW{prod_q[PSZ-1]}}, prod_q});
      end

      if (rd_en) begin
        rd_x_q <= c_q ? hist_q_q[rd_k] : hist_i_q[rd_k];
        rd_c_q <= rom[coef_idx];
      end

      if (in_calc)   prod_q <= rd_x_q * rd_c_q;
      if (calc_done) word_q <= sat_word;
    end
  end

endmodule

// File: tb/tb_fir_interpolator.sv
// Bench for fir_interpolator: three instances (ramp, DC and full-scale coefficients) driven
// in lockstep and checked against a plain-arithmetic polyphase reference model.
module tb_fir_interpolator;

  localparam int L    = 8;
  localparam int NT   = 4;
  localparam int TAPS = 32;

  function automatic logic [TAPS*16-1:0] ramp_coeffs();
    logic [TAPS*16-1:0] r;
    for (int j = 0; j < TAPS; j++) r[j*16 +: 16] = 16'((j + 1) << 10);
    return r;
  endfunction

  localparam logic [TAPS*16-1:0] CoefImp = ramp_coeffs();
  localparam logic [TAPS*16-1:0] CoefDc  = {TAPS{16'h4000}};
  localparam logic [TAPS*16-1:0] CoefSat = {TAPS{16'h7FFF}};

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_w;
  logic        out_ready;
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        out_q     [3];
  logic [15:0] out_w     [3];

  int coef   [3][TAPS];
  int hist_i [NT];
  int hist_q [NT];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fir_interpolator #(.COEFFS(CoefImp)) u_imp (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_w), .in_ready(in_ready[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out(out_w[0]), .out_q(out_q[0])
  );
  fir_interpolator #(.COEFFS(CoefDc)) u_dc (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_w), .in_ready(in_ready[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out(out_w[1]), .out_q(out_q[1])
  );
  fir_interpolator #(.COEFFS(CoefSat)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_w), .in_ready(in_ready[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready), .out(out_w[2]), .out_q(out_q[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // y[p] = sat((sum_k x[n-k] * h[p + L*k] + 2^14) >> 15)
  function automatic logic [15:0] model(input int d, input int p, input bit qsel);
    longint acc = 64'sd16384;
    longint x;
    for (int k = 0; k < NT; k++) begin
      x = qsel ? hist_q[k] : hist_i[k];
      acc += x * longint'(coef[d][p + L*k]);
    end
    acc = acc >>> 15;
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    return acc[15:0];
  endfunction

  task automatic clear_model();
    for (int k = 0; k < NT; k++) begin
      hist_i[k] = 0;
      hist_q[k] = 0;
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_w     = w;
    while (!in_ready[0] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("input accept wait", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_sample(input logic [15:0] i, input logic [15:0] q, input int gap);
    push_word(i);
    repeat (gap) begin
      @(posedge clk); #1;
    end
    push_word(q);
    for (int k = NT - 1; k > 0; k--) begin
      hist_i[k] = hist_i[k-1];
      hist_q[k] = hist_q[k-1];
    end
    hist_i[0] = int'($signed(i));
    hist_q[0] = int'($signed(q));
  endtask

  // Drains the 2*L words of one sample; bp = word index stalled for 10 cycles (-1: none).
  task automatic collect(input int bp, input bit noise, input bit fix_en, input int fix_d,
                         input logic [15:0] fix_i, input logic [15:0] fix_q);
    if (noise) begin
      in_valid = 1'b1;
      in_w     = 16'hDEAD;
    end
    for (int w = 0; w < 2*L; w++) begin
      int p = w / 2;
      bit qs = w[0];
      int cnt = 0;
      while (!out_valid[0] && cnt < 100) begin
        @(posedge clk); #1;
        cnt++;
      end
      check($sformatf("latency w%0d", w), cnt, NT + 3);
      for (int d = 0; d < 3; d++)
        check($sformatf("out d%0d p%0d %s", d, p, qs ? "Q" : "I"), 32'(out_w[d]),
              32'(model(d, p, qs)));
      check($sformatf("out_q w%0d", w), 32'(out_q[0]), 32'(qs));
      if (noise) check("in_ready while busy", 32'(in_ready[0]), 32'd0);
      if (fix_en) check($sformatf("fixed d%0d w%0d", fix_d, w), 32'(out_w[fix_d]),
                        32'(qs ? fix_q : fix_i));
      if (w == bp) begin
        out_ready = 1'b0;
        repeat (10) begin
          @(posedge clk); #1;
          check("stall hold", {13'd0, out_valid[0], out_q[0], in_ready[0], out_w[0]},
                {13'd0, 1'b1, qs, 1'b0, model(0, p, qs)});
        end
        out_ready = 1'b1;
      end
      if (noise && w == 2*L - 1) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    check("in_ready after last word", 32'(in_ready[0]), 32'd1);
  endtask

  initial begin
    logic [TAPS*16-1:0] cv [3];
    logic [15:0] ri, rq;
    cv[0] = CoefImp;
    cv[1] = CoefDc;
    cv[2] = CoefSat;
    for (int d = 0; d < 3; d++)
      for (int j = 0; j < TAPS; j++) coef[d][j] = int'($signed(cv[d][j*16 +: 16]));
    clear_model();

    // Reset state
    reset = 1'b0; in_valid = 1'b0; in_w = '0; out_ready = 1'b1;
    #1;
    check("reset out_valid", 32'(out_valid[0]), 32'd0);
    check("reset in_ready", 32'(in_ready[0]), 32'd0);
    check("reset out", 32'(out_w[0]), 32'd0);
    check("reset out_q", 32'(out_q[0]), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    check("in_ready before first edge", 32'(in_ready[0]), 32'd0);
    @(posedge clk); #1;
    check("in_ready after first edge", 32'(in_ready[0]), 32'd1);

    // DC gain: from the 4th sample the history is full
    for (int s = 0; s < 8; s++) begin
      send_sample(16'h2000, 16'hE000, 0);
      collect(-1, 1'b0, s >= 3, 1, 16'h4000, 16'hC000);
    end

    // Reset in the middle of a computation
    send_sample(16'h1234, 16'h4321, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    check("mid-calc reset out_valid", 32'(out_valid[0]), 32'd0);
    check("mid-calc reset in_ready", 32'(in_ready[0]), 32'd0);
    check("mid-calc reset out", 32'(out_w[0]), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    check("in_ready at release", 32'(in_ready[0]), 32'd0);
    @(posedge clk); #1;
    check("in_ready after release", 32'(in_ready[0]), 32'd1);
    clear_model();

    // Impulse through the ramp filter (history starts from zero after reset)
    send_sample(16'h7FFF, 16'h0000, 0);
    collect(-1, 1'b0, 1'b0, 0, 16'h0, 16'h0);
    for (int s = 0; s < 3; s++) begin
      send_sample(16'h0000, 16'h0000, 0);
      collect(-1, 1'b0, 1'b0, 0, 16'h0, 16'h0);
    end

    // Saturation with full-scale inputs and coefficients
    for (int s = 0; s < 4; s++) begin
      send_sample(16'h7FFF, 16'h8000, 0);
      collect(-1, 1'b0, s >= 3, 2, 16'h7FFF, 16'h8000);
    end

    // Random samples, one with a 10-cycle stall on p3 Q
    for (int s = 0; s < 4; s++) begin
      ri = 16'($urandom);
      rq = 16'($urandom);
      send_sample(ri, rq, 0);
      collect((s == 1) ? 7 : -1, 1'b0, 1'b0, 0, 16'h0, 16'h0);
    end

    // Gap between I and Q, then in_valid held high while busy
    ri = 16'($urandom);
    rq = 16'($urandom);
    send_sample(ri, rq, 5);
    collect(-1, 1'b1, 1'b0, 0, 16'h0, 16'h0);
    ri = 16'($urandom);
    rq = 16'($urandom);
    send_sample(ri, rq, 0);
    collect(-1, 1'b0, 1'b0, 0, 16'h0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
